// File: rtl/pid_pkg.sv
// Shared constants for the PID channel scheduler: default widths, config field
// select codes and the named steps within a channel slot.
package pid_pkg;

  localparam int CW_DEF     = 6;
  localparam int STATEW_DEF = 4;

  typedef enum logic [1:0] {
    SEL_KP = 2'd0,
    SEL_KI = 2'd1,
    SEL_KD = 2'd2,
    SEL_EN = 2'd3
  } cfg_sel_e;

  localparam int ST_SAMPLE = 0;
  localparam int ST_LOAD   = 1;
  localparam int ST_OUT    = 8;
  localparam int ST_CE_SET = 9;
  localparam int ST_CE_CLR = 15;

endpackage

// File: rtl/pid_coef_bank.sv
// Per-channel coefficient storage: a shadow set written by the config port and
// an active set refreshed from the shadow at the start of each channel slot.
module pid_coef_bank
  import pid_pkg::*;
#(
  parameter int aw = 1,
  parameter int cw = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [aw-1:0] wch_i,
  input  logic [1:0]    wsel_i,
  input  logic [cw-1:0] wdata_i,
  input  logic          copy_i,
  input  logic [aw-1:0] rch_i,
  output logic [cw-1:0] kp_o,
  output logic [cw-1:0] ki_o,
  output logic [cw-1:0] kd_o,
  output logic          act_en_o,
  output logic          shd_en_o
);

  localparam int AN = 1 << aw;
  localparam logic [cw-1:0] MOST_NEG = {1'b1, {(cw-1){1'b0}}};
  localparam logic [cw-1:0] SAT_NEG  = {1'b1, {(cw-2){1'b0}}, 1'b1};

  logic [cw-1:0] shd_kp_q [AN];
  logic [cw-1:0] shd_ki_q [AN];
  logic [cw-1:0] shd_kd_q [AN];
  logic [cw-1:0] act_kp_q [AN];
  logic [cw-1:0] act_ki_q [AN];
  logic [cw-1:0] act_kd_q [AN];
  logic [AN-1:0] shd_en_q;
  logic [AN-1:0] act_en_q;
  logic [cw-1:0] wcoef;

  // Fold the most negative code onto its neighbour so every stored value negates.
  assign wcoef = (wdata_i == MOST_NEG) ? SAT_NEG : wdata_i;

  // Copy reads the shadow before this edge's write lands, so a colliding
  // write only becomes active one sweep later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < AN; i++) begin
        shd_kp_q[i] <= '0;
        shd_ki_q[i] <= '0;
        shd_kd_q[i] <= '0;
        act_kp_q[i] <= '0;
        act_ki_q[i] <= '0;
        act_kd_q[i] <= '0;
      end
      shd_en_q <= '0;
      act_en_q <= '0;
    end else begin
      if (copy_i) begin
        act_kp_q[rch_i] <= shd_kp_q[rch_i];
        act_ki_q[rch_i] <= shd_ki_q[rch_i];
        act_kd_q[rch_i] <= shd_kd_q[rch_i];
        act_en_q[rch_i] <= shd_en_q[rch_i];
      end
      if (we_i) begin
        case (cfg_sel_e'(wsel_i))
          SEL_KP: shd_kp_q[wch_i] <= wcoef;
          SEL_KI: shd_ki_q[wch_i] <= wcoef;
          SEL_KD: shd_kd_q[wch_i] <= wcoef;
          SEL_EN: shd_en_q[wch_i] <= wdata_i[0];
          default: ;
        endcase
      end
    end
  end

  assign kp_o     = act_kp_q[rch_i];
  assign ki_o     = act_ki_q[rch_i];
  assign kd_o     = act_kd_q[rch_i];
  assign act_en_o = act_en_q[rch_i];
  assign shd_en_o = shd_en_q[rch_i];

endmodule

// File: rtl/pid_sched.sv
// Time-multiplexed PID scheduler: a free-running counter walks every channel
// through a fixed slot of steps, strobing the datapath and the sensor request.
module pid_sched
  import pid_pkg::*;
#(
  parameter int psc    = 15,
  parameter int aw     = 1,
  parameter int statew = STATEW_DEF,
  parameter int cw     = CW_DEF
) (
  input  logic                 clk_pid,
  input  logic                 reset_n,
  input  logic                 cfg_we,
  input  logic [aw-1:0]        cfg_ch,
  input  logic [1:0]           cfg_sel,
  input  logic [cw-1:0]        cfg_data,
  output logic [aw-1:0]        a,
  output logic [statew-1:0]    state,
  output logic                 calc,
  output logic                 clr,
  output logic [cw-1:0]        KP,
  output logic [cw-1:0]        KI,
  output logic [cw-1:0]        KD,
  output logic                 err_req,
  input  logic                 err_ack,
  output logic                 ce,
  output logic [(1<<aw)-1:0]   err_miss
);

  localparam int LW = psc - aw - statew;
  localparam int AN = 1 << aw;

  logic [psc-1:0] u_q;
  logic           err_req_q, err_req_d;
  logic           ce_q, ce_d;
  logic [AN-1:0]  err_miss_q, err_miss_d;
  logic           t, slot_start, step_load, act_en, shd_en;

  assign a          = u_q[psc-1 -: aw];
  assign state      = u_q[psc-aw-1 -: statew];
  assign t          = (u_q[LW-1:0] == '0);
  assign slot_start = t && (state == statew'(ST_SAMPLE));
  assign step_load  = t && (state == statew'(ST_LOAD));

  pid_coef_bank #(.aw(aw), .cw(cw)) u_bank (
    .clk_i    (clk_pid),
    .rst_ni   (reset_n),
    .we_i     (cfg_we),
    .wch_i    (cfg_ch),
    .wsel_i   (cfg_sel),
    .wdata_i  (cfg_data),
    .copy_i   (slot_start),
    .rch_i    (a),
    .kp_o     (KP),
    .ki_o     (KI),
    .kd_o     (KD),
    .act_en_o (act_en),
    .shd_en_o (shd_en)
  );

  assign calc = t && act_en && (state >= statew'(ST_LOAD)) && (state <= statew'(ST_OUT));
  assign clr  = slot_start && shd_en && !act_en;

  // err_req/err_ack: err_req is a level request raised at slot start for an
  // enabled channel. An err_ack sampled while err_req is high completes it and
  // err_req drops on the next clock; err_ack while err_req is low is ignored.
  // A request still pending at step 1 expires and sets that channel's err_miss.
  always_comb begin
    err_req_d = err_req_q;
    if (err_req_q && err_ack) err_req_d = 1'b0;
    if (step_load)            err_req_d = 1'b0;
    if (slot_start)           err_req_d = shd_en;
  end

  always_comb begin
    ce_d = ce_q;
    if (t && (state == statew'(ST_CE_SET)) && act_en) ce_d = 1'b1;
    if (t && (state == statew'(ST_CE_CLR)))           ce_d = 1'b0;
  end

  always_comb begin
    err_miss_d = err_miss_q;
    if (cfg_we && (cfg_sel == SEL_EN)) err_miss_d[cfg_ch] = 1'b0;
    if (step_load && err_req_q)        err_miss_d[a]      = 1'b1;
  end

  always_ff @(posedge clk_pid or negedge reset_n) begin
    if (!reset_n) begin
      u_q        <= '0;
      err_req_q  <= 1'b0;
      ce_q       <= 1'b0;
      err_miss_q <= '0;
    end else begin
      u_q        <= u_q + psc'(1);
      err_req_q  <= err_req_d;
      ce_q       <= ce_d;
      err_miss_q <= err_miss_d;
    end
  end

  assign err_req  = err_req_q;
  assign ce       = ce_q;
  assign err_miss = err_miss_q;

endmodule

// File: tb/tb_pid_sched.sv
// Scoreboard bench for pid_sched (psc=8, aw=1): the driver pushes the expected
// per-clock output vector, a negedge monitor pops and compares it.
module tb_pid_sched;

  localparam int PSC = 8;
  localparam int AW  = 1;
  localparam int SW  = 4;
  localparam int CW  = 6;
  localparam int W   = 29;

  logic          clk_pid  = 1'b0;
  logic          reset_n  = 1'b0;
  logic          cfg_we   = 1'b0;
  logic [AW-1:0] cfg_ch   = '0;
  logic [1:0]    cfg_sel  = '0;
  logic [CW-1:0] cfg_data = '0;
  logic          err_ack  = 1'b0;
  logic [AW-1:0] a;
  logic [SW-1:0] state;
  logic          calc, clr, err_req, ce;
  logic [CW-1:0] KP, KI, KD;
  logic [1:0]    err_miss;

  pid_sched #(.psc(PSC), .aw(AW), .statew(SW), .cw(CW)) dut (
    .clk_pid  (clk_pid),
    .reset_n  (reset_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .a        (a),
    .state    (state),
    .calc     (calc),
    .clr      (clr),
    .KP       (KP),
    .KI       (KI),
    .KD       (KD),
    .err_req  (err_req),
    .err_ack  (err_ack),
    .ce       (ce),
    .err_miss (err_miss)
  );

  // clock/reset
  always #5 clk_pid = ~clk_pid;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // reference model: clocks since reset release plus the programmer-visible registers
  int          k;
  logic [5:0]  m_skp[2], m_ski[2], m_skd[2], m_akp[2], m_aki[2], m_akd[2];
  logic        m_sen[2], m_aen[2];
  logic        m_req, m_ce;
  logic [1:0]  m_miss;

  function automatic logic [W-1:0] pack(input logic pa, input logic [3:0] ps, input logic pc,
                                        input logic pr, input logic [5:0] pkp, input logic [5:0] pki,
                                        input logic [5:0] pkd, input logic pq, input logic pe,
                                        input logic [1:0] pm);
    return {pa, ps, pc, pr, pkp, pki, pkd, pq, pe, pm};
  endfunction

  function automatic logic [5:0] sat(input logic [5:0] d);
    return (d == 6'b100000) ? 6'b100001 : d;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 2; i++) begin
      m_skp[i] = '0; m_ski[i] = '0; m_skd[i] = '0;
      m_akp[i] = '0; m_aki[i] = '0; m_akd[i] = '0;
      m_sen[i] = 1'b0; m_aen[i] = 1'b0;
    end
    m_req  = 1'b0;
    m_ce   = 1'b0;
    m_miss = '0;
  endtask

  // driver: one clock of stimulus, expected vector for that clock, then model advance
  task automatic cycle(input logic rst, input logic we, input int ch, input int sel,
                       input logic [5:0] data, input logic ack);
    int u, cm, st;
    logic tick, e_calc, e_clr, old_sen, miss_set;
    @(posedge clk_pid);
    #1;
    reset_n  = rst;
    cfg_we   = we;
    cfg_ch   = 1'(ch);
    cfg_sel  = 2'(sel);
    cfg_data = data;
    err_ack  = ack;
    if (!rst) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      u    = k % 256;
      cm   = u / 128;
      st   = (u / 8) % 16;
      tick = (u % 8 == 0);
      e_calc = tick && m_aen[cm] && st >= 1 && st <= 8;
      e_clr  = tick && st == 0 && m_sen[cm] && !m_aen[cm];
      exp_q.push_back(pack(1'(cm), 4'(st), e_calc, e_clr, m_akp[cm], m_aki[cm], m_akd[cm],
                           m_req, m_ce, m_miss));
      old_sen  = m_sen[cm];
      miss_set = tick && st == 1 && m_req;
      if (tick && st == 9 && m_aen[cm]) m_ce = 1'b1;
      if (tick && st == 15) m_ce = 1'b0;
      if (tick && st == 0) begin
        m_akp[cm] = m_skp[cm]; m_aki[cm] = m_ski[cm];
        m_akd[cm] = m_skd[cm]; m_aen[cm] = m_sen[cm];
      end
      if (tick && st == 0)      m_req = old_sen;
      else if (tick && st == 1) m_req = 1'b0;
      else if (m_req && ack)    m_req = 1'b0;
      if (we) begin
        case (sel)
          0: m_skp[ch] = sat(data);
          1: m_ski[ch] = sat(data);
          2: m_skd[ch] = sat(data);
          default: begin m_sen[ch] = data[0]; m_miss[ch] = 1'b0; end
        endcase
      end
      if (miss_set) m_miss[cm] = 1'b1;
      k++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, 0, 0, 6'd0, 1'b0);
  endtask

  task automatic wr(input int ch, input int sel, input logic [5:0] data);
    cycle(1'b1, 1'b1, ch, sel, data, 1'b0);
  endtask

  // advance until the next clock to be driven sits at the given position in the sweep
  task automatic run_to(input int target);
    do idle(1); while (k % 256 != target);
  endtask

  // monitor
  always @(negedge clk_pid) begin
    logic [W-1:0] got, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = pack(a, state, calc, clr, KP, KI, KD, err_req, ce, err_miss);
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL vec%0d {a,state,calc,clr,KP,KI,KD,req,ce,miss} got=%h exp=%h",
                 n_vec, got, e);
      end
    end
  end

  initial begin
    repeat (3) cycle(1'b0, 1'b0, 0, 0, 6'd0, 1'b0);
    idle(130);
    wr(0, 0, 6'd10);
    wr(0, 1, 6'd11);
    wr(0, 2, 6'd1);
    wr(0, 3, 6'd1);
    run_to(0);
    idle(3);
    cycle(1'b1, 1'b0, 0, 0, 6'd0, 1'b1);
    run_to(40);
    wr(0, 0, 6'h3B);
    run_to(0);
    run_to(0);
    wr(0, 2, 6'd7);
    run_to(5);
    wr(0, 1, 6'h20);
    wr(1, 0, 6'($urandom_range(0, 63)));
    wr(1, 1, 6'($urandom_range(0, 63)));
    wr(1, 2, 6'h20);
    wr(1, 3, 6'd1);
    run_to(0);
    run_to(20);
    wr(0, 3, 6'd1);
    repeat (1500) begin
      cycle(1'b1, ($urandom_range(0, 39) == 0), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
            ($urandom_range(0, 7) == 0));
    end
    wr(0, 3, 6'd1);
    run_to(0);
    run_to(100);
    repeat (3) cycle(1'b0, 1'b0, 0, 0, 6'd0, 1'b0);
    idle(300);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_pid);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
